// File: rtl/msx_ppi_slot_pkg.sv
// Shared definitions for the MSX PPI / primary-slot stage: PPI port offsets,
// the mode-word flag bit and the M1 wait-state encoding.
package msx_pkg;

    localparam logic [1:0] PPI_PORT_SLOT  = 2'd0;
    localparam logic [1:0] PPI_PORT_KB    = 2'd1;
    localparam logic [1:0] PPI_PORT_PORTC = 2'd2;
    localparam logic [1:0] PPI_PORT_CTRL  = 2'd3;

    // Control-port bit distinguishing a mode word from a port C bit set/reset.
    localparam int unsigned PPI_MODE_BIT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } wait_state_t;

endpackage

// File: rtl/msx_ppi_slot_if.sv
// CPU-side bus bundle between the T80 and the PPI/slot stage.
// master = CPU side, slave = PPI/slot stage.
interface msx_ppi_slot_if;

    logic [15:0] a;
    logic [7:0]  d_from_cpu;
    logic        iorq_n;
    logic        mreq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic [7:0]  ppi_dout;
    logic        ppi_oe;
    logic        wait_n;

    modport master (
        output a, d_from_cpu, iorq_n, mreq_n, rd_n, wr_n, m1_n,
        input  ppi_dout, ppi_oe, wait_n
    );

    modport slave (
        input  a, d_from_cpu, iorq_n, mreq_n, rd_n, wr_n, m1_n,
        output ppi_dout, ppi_oe, wait_n
    );

endinterface

// File: rtl/msx_ppi_slot_m1_wait.sv
// MSX M1 wait-state generator: one T-state of WAIT per opcode fetch.
// Only compiled when MSX_M1_WAIT_EN is defined.
`ifdef MSX_M1_WAIT_EN
module msx_m1_wait
    import msx_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ce_3m58_p,
    input  logic m1_n,
    input  logic mreq_n,
    output logic wait_n
);

    wait_state_t state_q, state_d;

    // State register; reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and WAIT output; an M1 abort in WAIT drops straight to IDLE.
    always_comb begin
        state_d = state_q;
        wait_n  = (state_q != WAIT);
        unique case (state_q)
            IDLE: if (!m1_n && !mreq_n) state_d = WAIT;
            WAIT: begin
                if (m1_n)           state_d = IDLE;
                else if (ce_3m58_p) state_d = HOLD;
            end
            HOLD: if (m1_n) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule
`endif

// File: rtl/msx_ppi_slot.sv
// MSX1 PPI (ports A8h-ABh) plus primary-slot resolution of the current page.
// Optional feature macro: MSX_M1_WAIT_EN (M1 wait-state insertion).
module msx_ppi_slot
    import msx_pkg::*;
#(
    parameter logic [7:0] PORT_BASE = 8'hA8,
    parameter logic [7:0] SLOT_RST  = 8'h00
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce_3m58_p,
    msx_ppi_slot_if.slave  bus,
    input  logic [7:0]     kb_col,
    output logic [1:0]     prim_slot,
    output logic [3:0]     kb_row,
    output logic           cas_motor_n,
    output logic           cas_out,
    output logic           caps_led,
    output logic           click
);

    logic [7:0] slot_q, slot_d;
    logic [7:0] portc_q, portc_d;
    logic       wr_q;
    logic       io_sel;
    logic       commit;

    // INTA (M1 and IORQ both low) never selects the PPI.
    assign io_sel = !bus.iorq_n && bus.m1_n && (bus.a[7:2] == PORT_BASE[7:2]);
    // Falling edge of WR seen inside the select: one commit per access.
    assign commit = io_sel && !bus.wr_n && wr_q;

    // Register-write decode for the commit clock.
    always_comb begin
        slot_d  = slot_q;
        portc_d = portc_q;
        if (commit) begin
            unique case (bus.a[1:0])
                PPI_PORT_SLOT:  slot_d = bus.d_from_cpu;
                PPI_PORT_KB:    ;
                PPI_PORT_PORTC: portc_d = bus.d_from_cpu;
                PPI_PORT_CTRL: begin
                    if (bus.d_from_cpu[PPI_MODE_BIT]) begin
                        portc_d = '0;
                        slot_d  = '0;
                    end else begin
                        portc_d[bus.d_from_cpu[3:1]] = bus.d_from_cpu[0];
                    end
                end
                default: ;
            endcase
        end
    end

    // PPI state and WR edge history; reset beats a simultaneous commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q  <= SLOT_RST;
            portc_q <= '0;
            wr_q    <= 1'b1;
        end else begin
            slot_q  <= slot_d;
            portc_q <= portc_d;
            wr_q    <= bus.wr_n;
        end
    end

    // Zero-latency read mux toward the CPU data bus.
    always_comb begin
        bus.ppi_oe   = io_sel && !bus.rd_n;
        bus.ppi_dout = '1;
        if (bus.ppi_oe) begin
            unique case (bus.a[1:0])
                PPI_PORT_SLOT:  bus.ppi_dout = slot_q;
                PPI_PORT_KB:    bus.ppi_dout = kb_col;
                PPI_PORT_PORTC: bus.ppi_dout = portc_q;
                default:        bus.ppi_dout = '1;
            endcase
        end
    end

    // Primary slot of the page addressed by a[15:14].
    always_comb begin
        unique case (bus.a[15:14])
            2'd0:    prim_slot = slot_q[1:0];
            2'd1:    prim_slot = slot_q[3:2];
            2'd2:    prim_slot = slot_q[5:4];
            default: prim_slot = slot_q[7:6];
        endcase
    end

    assign kb_row      = portc_q[3:0];
    assign cas_motor_n = portc_q[4];
    assign cas_out     = portc_q[5];
    assign caps_led    = ~portc_q[6];
    assign click       = portc_q[7];

    logic unused_addr;
    assign unused_addr = &{1'b0, bus.a[13:8]};

`ifdef MSX_M1_WAIT_EN
    msx_m1_wait u_m1_wait (
        .clk       (clk),
        .reset     (reset),
        .ce_3m58_p (ce_3m58_p),
        .m1_n      (bus.m1_n),
        .mreq_n    (bus.mreq_n),
        .wait_n    (bus.wait_n)
    );
`else
    assign bus.wait_n = 1'b1;

    logic unused_wait_inputs;
    assign unused_wait_inputs = &{1'b0, ce_3m58_p, bus.mreq_n};
`endif

endmodule
